// File: rtl/conv2d_stream_engine.sv
// Streaming 2-D valid convolution: loads an M x M image and an F x F kernel serially,
// then computes each output window with one sequential MAC and emits results on a valid/ready port.
module conv2d_stream_engine #(
  parameter int DW     = 8,
  parameter int M      = 3,
  parameter int F      = 2,
  parameter int OW     = 20,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    stride,
  output logic [OW-1:0] out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done,
  output logic          busy
);

  localparam int NPIX = M * M;
  localparam int KN   = F * F;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int KAW  = (KN > 1) ? $clog2(KN) : 1;
  localparam int PW   = $clog2(M + 16) + 1;

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_OUT, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   beat_q, beat_d;
  logic            full_q, full_d;
  logic [3:0]      s_q, s_d;
  logic [PW-1:0]   row_q, row_d, col_q, col_d, kr_q, kr_d, kc_q, kc_d;
  logic [OW-1:0]   acc_q, acc_d, out_q, out_d;
  logic            out_valid_q, out_valid_d, done_q, done_d;

  logic [DW-1:0]   img_mem [NPIX];
  logic [DW-1:0]   ker_mem [KN];
  logic [DW-1:0]   img_v, ker_v;
  logic [2*DW-1:0] prod;
  logic [OW-1:0]   prod_ext;
  logic            beat_fire, out_fire;
  int              img_idx, ker_idx;

  // full_q gives one settle cycle after the last beat so its write lands before the first MAC.
  assign in_ready  = (state_q == ST_LOAD) && !full_q;
  assign beat_fire = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_LOAD);

  always_comb begin
    img_idx = (int'(row_q) + int'(kr_q)) * M + int'(col_q) + int'(kc_q);
    ker_idx = int'(kr_q) * F + int'(kc_q);
    img_v   = img_mem[img_idx[AW-1:0]];
    ker_v   = ker_mem[ker_idx[KAW-1:0]];
  end

  generate
    if (SIGNED != 0) begin : g_signed
      assign prod     = $signed({{DW{img_v[DW-1]}}, img_v}) * $signed({{DW{ker_v[DW-1]}}, ker_v});
      assign prod_ext = OW'($signed(prod));
    end else begin : g_unsigned
      assign prod     = {{DW{1'b0}}, img_v} * {{DW{1'b0}}, ker_v};
      assign prod_ext = OW'(prod);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst && beat_fire) begin
      img_mem[beat_q] <= a;
      if (int'(beat_q) < KN) ker_mem[beat_q[KAW-1:0]] <= b;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    full_d      = full_q;
    s_d         = s_q;
    row_d       = row_q;
    col_d       = col_q;
    kr_d        = kr_q;
    kc_d        = kc_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (full_q) begin
          full_d  = 1'b0;
          state_d = ST_COMPUTE;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          kr_d    = '0;
          kc_d    = '0;
        end else if (beat_fire) begin
          if (beat_q == '0) s_d = (stride == 4'd0) ? 4'd1 : stride;
          if (beat_q == AW'(NPIX - 1)) begin
            beat_d = '0;
            full_d = 1'b1;
          end else begin
            beat_d = beat_q + AW'(1);
          end
        end
      end
      ST_COMPUTE: begin
        acc_d = acc_q + prod_ext;
        if (kc_q == PW'(F - 1)) begin
          kc_d = '0;
          if (kr_q == PW'(F - 1)) begin
            kr_d        = '0;
            out_d       = acc_q + prod_ext;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
          end else begin
            kr_d = kr_q + PW'(1);
          end
        end else begin
          kc_d = kc_q + PW'(1);
        end
      end
      ST_OUT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          if (int'(col_q) + int'(s_q) + F <= M) begin
            col_d   = col_q + PW'(s_q);
            state_d = ST_COMPUTE;
          end else if (int'(row_q) + int'(s_q) + F <= M) begin
            col_d   = '0;
            row_d   = row_q + PW'(s_q);
            state_d = ST_COMPUTE;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      beat_q      <= '0;
      full_q      <= 1'b0;
      s_q         <= 4'd1;
      row_q       <= '0;
      col_q       <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      full_q      <= full_d;
      s_q         <= s_d;
      row_q       <= row_d;
      col_q       <= col_d;
      kr_q        <= kr_d;
      kc_q        <= kc_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine: an unsigned and a signed instance share one stimulus.
module tb_conv2d_stream_engine;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [7:0]  a, b;
  logic [3:0]  stride;

  logic        u_in_ready, u_out_valid, u_done, u_busy;
  logic [19:0] u_out;
  logic        s_in_ready, s_out_valid, s_done, s_busy;
  logic [19:0] s_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv2d_stream_engine #(.DW(8), .M(3), .F(2), .OW(20), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
    .a(a), .b(b), .stride(stride), .out(u_out), .out_valid(u_out_valid),
    .out_ready(out_ready), .done(u_done), .busy(u_busy)
  );

  conv2d_stream_engine #(.DW(8), .M(3), .F(2), .OW(20), .SIGNED(1)) u_sdut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .stride(stride), .out(s_out), .out_valid(s_out_valid),
    .out_ready(out_ready), .done(s_done), .busy(s_busy)
  );

  function automatic logic [19:0] get_out(input int sel);
    return (sel != 0) ? s_out : u_out;
  endfunction
  function automatic logic get_valid(input int sel);
    return (sel != 0) ? s_out_valid : u_out_valid;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel != 0) ? s_done : u_done;
  endfunction
  function automatic logic get_ready(input int sel);
    return (sel != 0) ? s_in_ready : u_in_ready;
  endfunction

  // mode 0: a=1..9, kernel 1,2,3,4; mode 1: a=-1, kernel 1,1,1,1. Trailing b beats are 2.
  task automatic load_frame(input int st, input int mode, input bit gaps);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (get_ready(mode) !== 1'b1) begin
        errors++;
        $display("FAIL load_in_ready beat %0d got %b want 1", k, get_ready(mode));
      end
      in_valid = 1'b1;
      a        = (mode != 0) ? 8'hFF : 8'(k + 1);
      b        = (k < 4) ? ((mode != 0) ? 8'd1 : 8'(k + 1)) : 8'd2;
      stride   = 4'(st);
      @(posedge clk); #1;
      if (gaps && k < 8) begin
        in_valid = 1'b0;
        a        = 8'd0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    stride   = 4'd3;
  endtask

  task automatic expect_frame(input string name, input int sel, input int n,
                              input logic [19:0] e0, input logic [19:0] e1,
                              input logic [19:0] e2, input logic [19:0] e3,
                              input int stall, input bit junk);
    logic [19:0] exp_v [4];
    int got  = 0;
    int cyc  = 0;
    int due  = 5;
    int held = 0;
    exp_v = '{e0, e1, e2, e3};
    out_ready = (stall == 0);
    if (junk) begin
      in_valid = 1'b1;
      a        = 8'd99;
      b        = 8'd99;
    end
    while (got < n && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (junk && cyc == 2) begin
        checks++;
        if (get_ready(sel) !== 1'b0) begin
          errors++;
          $display("FAIL %s_in_ready_busy got %b want 0", name, get_ready(sel));
        end
      end
      if (junk && cyc == 8) in_valid = 1'b0;
      if (held > 0 && !get_valid(sel)) begin
        checks++;
        errors++;
        $display("FAIL %s_stall_drop at cycle %0d got out_valid 0 want 1", name, cyc);
      end
      if (get_valid(sel)) begin
        if (held == 0) begin
          checks++;
          if (cyc != due) begin
            errors++;
            $display("FAIL %s_timing idx %0d got cycle %0d want %0d", name, got, cyc, due);
          end
        end
        checks++;
        if (get_out(sel) !== exp_v[got]) begin
          errors++;
          $display("FAIL %s_value idx %0d got %h want %h", name, got, get_out(sel), exp_v[got]);
        end
        if (out_ready) begin
          got++;
          due  = cyc + 5;
          held = 0;
        end else begin
          held++;
          if (held == stall) begin
            out_ready = 1'b1;
            got++;
            due  = cyc + 5;
            held = 0;
          end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s_timeout got %0d results want %0d", name, got, n);
    end
    @(posedge clk); #1;
    checks++;
    if (get_done(sel) !== 1'b1 || get_valid(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got done %b valid %b want done 1 valid 0", name, get_done(sel), get_valid(sel));
    end
    @(posedge clk); #1;
    checks++;
    if (get_done(sel) !== 1'b0 || get_ready(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s_after_done got done %b in_ready %b want done 0 in_ready 1", name, get_done(sel), get_ready(sel));
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; stride = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++;
    if (u_out !== 20'd0 || u_out_valid !== 1'b0 || u_done !== 1'b0 || u_busy !== 1'b0 || u_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got out %h valid %b done %b busy %b in_ready %b want 0 0 0 0 1",
               u_out, u_out_valid, u_done, u_busy, u_in_ready);
    end
    checks++;
    if (s_out_valid !== 1'b0 || s_busy !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state_signed got valid %b busy %b in_ready %b want 0 0 1", s_out_valid, s_busy, s_in_ready);
    end
  endtask

  task automatic test_basic();
    load_frame(1, 0, 1'b0);
    expect_frame("basic", 0, 4, 20'd37, 20'd47, 20'd67, 20'd77, 0, 1'b0);
  endtask

  task automatic test_stride();
    load_frame(2, 0, 1'b0);
    expect_frame("stride2", 0, 1, 20'd37, 20'd0, 20'd0, 20'd0, 0, 1'b0);
    load_frame(0, 0, 1'b0);
    expect_frame("stride0", 0, 4, 20'd37, 20'd47, 20'd67, 20'd77, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    load_frame(1, 0, 1'b0);
    expect_frame("backpressure", 0, 4, 20'd37, 20'd47, 20'd67, 20'd77, 10, 1'b0);
  endtask

  task automatic test_signed();
    load_frame(1, 1, 1'b0);
    expect_frame("signed", 1, 4, 20'hFFFFC, 20'hFFFFC, 20'hFFFFC, 20'hFFFFC, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    load_frame(1, 0, 1'b0);
    out_ready = 1'b1;
    while (!u_out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (u_out !== 20'd37 || u_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_first got out %h valid %b want 25 1", u_out, u_out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (u_busy !== 1'b1 || u_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_computing got busy %b valid %b want 1 0", u_busy, u_out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (u_out_valid !== 1'b0 || u_busy !== 1'b0 || u_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_state got valid %b busy %b in_ready %b want 0 0 1", u_out_valid, u_busy, u_in_ready);
    end
    load_frame(1, 0, 1'b0);
    expect_frame("rstmid_fresh", 0, 4, 20'd37, 20'd47, 20'd67, 20'd77, 0, 1'b0);
  endtask

  task automatic test_gaps();
    load_frame(1, 0, 1'b1);
    expect_frame("gaps", 0, 4, 20'd37, 20'd47, 20'd67, 20'd77, 0, 1'b1);
    load_frame(1, 0, 1'b0);
    expect_frame("after_junk", 0, 4, 20'd37, 20'd47, 20'd67, 20'd77, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_backpressure();
    test_signed();
    test_reset_mid();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2d_stream_engine.md
Name: conv2d_stream_engine

Overview:
- Parametrised 2-D valid-convolution engine; successor to the fixed-size convolution block.
- Image and kernel elements stream in serially on a valid/ready input, then the engine computes every output window with a single sequential MAC.
- Results leave on a valid/ready output with backpressure.
- Adds generic data width, signed mode, runtime stride with zero-guard, output handshake, and busy/in_ready status.

Parameters:
- DW, 8, input element width (image and kernel).
- M, 3, image side length (M x M), M >= F.
- F, 2, kernel side length (F x F), F >= 1.
- OW, 20, output width; must be >= 2*DW + clog2(F*F).
- SIGNED, 0, 1 = treat a, b and the product as two's complement; 0 = unsigned.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts a beat (LOAD state only).
- a  in  DW  image element, row-major.
- b  in  DW  kernel element, row-major; sampled only on beats 0..F*F-1.
- stride  in  4  window step; sampled on the first accepted beat of a frame.
- out  out  OW  convolution result.
- out_valid  out  1  out holds a result.
- out_ready  in  1  downstream accepts result.
- done  out  1  one-cycle pulse after the last result of a frame is accepted.
- busy  out  1  high in COMPUTE, OUT and DONE.

Behaviour:
- Reset: state=LOAD; beat counter, row/col pointers and accumulator = 0; out=0, out_valid=0, done=0, busy=0, in_ready=1. Image/kernel storage need not clear. Reset mid-frame aborts it; the next beat after reset is beat 0.
- Handshakes:
  - Input beat accepted when in_valid && in_ready.
  - Output accepted when out_valid && out_ready.
  - out and out_valid hold stable while out_ready=0.
- States:
  - LOAD: accepted beat k stores a into img[k]; if k < F*F, b into ker[k]. Beat 0 also latches S = (stride==0) ? 1 : stride. After beat M*M-1: go to COMPUTE, in_ready=0, accumulator cleared, row=col=0.
  - COMPUTE: exactly F*F cycles, one MAC per cycle, kernel index i from 0 to F*F-1: acc += img[(row+i/F)*M + col+i%F] * ker[i]. Product is 2*DW bits, sign- or zero-extended to OW per SIGNED. Then go to OUT.
  - OUT: out=acc, out_valid=1. On handshake:
    - If col+S+F <= M: col += S and return to COMPUTE.
    - Else if row+S+F <= M: col=0, row += S, return to COMPUTE.
    - Else: go to DONE.
    - out_valid drops on the handshake edge.
  - DONE: done=1 for one cycle, then LOAD with in_ready=1.
- Output count: N = floor((M-F)/S)+1 per side, so N*N results in row-major window order.
- Latency:
  - out_valid first rises F*F+1 edges after the edge accepting the final input beat.
  - With out_ready held at 1, successive results are F*F+1 cycles apart.
- Wrap-around: accumulation is exact given the OW constraint; no saturation.
- in_valid while in_ready=0 is ignored: no storage, no stall.
- rst has priority over every other event in the same cycle.

Test Plan:
1. M=3, F=2, S=1, unsigned. Beats a=1..9; b=1,2,3,4 then 2,2,2,2,2 (ignored); out_ready=1 -> results 37, 47, 67, 77 in order, each F*F+1=5 cycles apart. done pulses once, one cycle after the handshake of 77. in_ready returns high the following cycle.
2. Same data, stride=2 -> exactly one result, 37, then done. stride=0 -> identical to case 1: 37, 47, 67, 77.
3. Backpressure, case 1 data: out_ready=0 for 10 cycles at the first result -> out holds 37 with out_valid=1 for all 10 cycles. The remaining sequence 47, 67, 77 is unchanged, and no MAC proceeds while OUT is stalled.
4. SIGNED=1, DW=8: all a=8'hFF (-1), b=1,1,1,1 -> four results each equal to -4 (OW-bit two's complement, 20'hFFFFC).
5. Assert rst for one cycle during COMPUTE of the second window -> next cycle out_valid=0, busy=0, in_ready=1. A fresh frame afterwards with case 1 data yields 37, 47, 67, 77.
6. in_valid pulsed with gaps (a 0 between beats), plus in_valid=1 during COMPUTE -> results still 37, 47, 67, 77, and extra beats during COMPUTE are not captured into the next frame.
